// File: rtl/bw_dcache_pkg.sv
// Shared types and pseudo-LRU tree helpers for the BlackWidow dcache way-selection logic.
// Tree nodes use heap order (node i has children 2i+1 and 2i+2); a node bit of 0 steers the victim left.
package bw_dcache_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FILL = 1'b1
   } dcway_state_t;

   // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Helpers are sized for the largest supported cache (8 ways, 7 tree nodes).
   localparam int PLRU_MAX_NODES = 7;
   localparam int PLRU_MAX_LEVELS = 3;

   // Point every node on way's path away from it; levels = log2(ways).
   function automatic logic [PLRU_MAX_NODES-1:0] plru_touch(
      input logic [PLRU_MAX_NODES-1:0]  tree,
      input logic [PLRU_MAX_LEVELS-1:0] way,
      input int                         levels
   );
      logic [PLRU_MAX_NODES-1:0]  t;
      logic [PLRU_MAX_LEVELS-1:0] idx;
      logic [PLRU_MAX_LEVELS-1:0] wsh;
      t   = tree;
      idx = 3'd0;
      wsh = way << (PLRU_MAX_LEVELS - levels);
      for (int l = 0; l < PLRU_MAX_LEVELS; l++) begin
         if (l < levels) begin
            t[idx] = ~wsh[2];
            idx    = {idx[1:0], 1'b0} + 3'd1 + {2'b00, wsh[2]};
            wsh    = {wsh[1:0], 1'b0};
         end else begin
            t = t;
         end
      end
      return t;
   endfunction

   // Point every node on way's path toward it, making it the next victim.
   function automatic logic [PLRU_MAX_NODES-1:0] plru_point(
      input logic [PLRU_MAX_NODES-1:0]  tree,
      input logic [PLRU_MAX_LEVELS-1:0] way,
      input int                         levels
   );
      logic [PLRU_MAX_NODES-1:0]  t;
      logic [PLRU_MAX_LEVELS-1:0] idx;
      logic [PLRU_MAX_LEVELS-1:0] wsh;
      t   = tree;
      idx = 3'd0;
      wsh = way << (PLRU_MAX_LEVELS - levels);
      for (int l = 0; l < PLRU_MAX_LEVELS; l++) begin
         if (l < levels) begin
            t[idx] = wsh[2];
            idx    = {idx[1:0], 1'b0} + 3'd1 + {2'b00, wsh[2]};
            wsh    = {wsh[1:0], 1'b0};
         end else begin
            t = t;
         end
      end
      return t;
   endfunction

   // Walk from the root following node bits; the way index builds up MSB first.
   function automatic logic [PLRU_MAX_LEVELS-1:0] plru_victim(
      input logic [PLRU_MAX_NODES-1:0] tree,
      input int                        levels
   );
      logic [PLRU_MAX_LEVELS-1:0] idx;
      logic [PLRU_MAX_LEVELS-1:0] w;
      idx = 3'd0;
      w   = 3'd0;
      for (int l = 0; l < PLRU_MAX_LEVELS; l++) begin
         if (l < levels) begin
            w   = {w[1:0], tree[idx]};
            idx = {idx[1:0], 1'b0} + 3'd1 + {2'b00, tree[idx]};
         end else begin
            w = w;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/bw_dcache_lfsr16.sv
// Free-running 16-bit Galois LFSR, loaded with SEED while rst is high.
module bw_dcache_lfsr16
   import bw_dcache_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] q
);

   // Shift right, folding the outgoing bit back through the taps.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= SEED;
      end else begin
         q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
      end
   end

endmodule

// File: rtl/bw_dcache_way_sel.sv
// Dcache way selection / replacement: victim choice on miss, write way for store hits and fills.
// Build option BW_DCACHE_PLRU_EN selects tree pseudo-LRU; otherwise the LFSR picks the policy victim.
module bw_dcache_way_sel
   import bw_dcache_pkg::*;
#(
   parameter int          WAYS      = 4,
   parameter int          SETS      = 64,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    acc_v,
   input  logic                    acc_store,
   input  logic [$clog2(SETS)-1:0] acc_set,
   input  logic                    hit,
   input  logic [$clog2(WAYS)-1:0] hit_way,
   input  logic [WAYS-1:0]         way_valid,
   input  logic                    miss_v,
   output logic                    miss_rdy,
   input  logic                    fill_done,
   input  logic                    inv_v,
   input  logic [$clog2(WAYS)-1:0] inv_way,
   output logic [$clog2(WAYS)-1:0] wway,
   output logic                    wway_v
);

   localparam int WAY_W = $clog2(WAYS);
   localparam int SET_W = $clog2(SETS);

   dcway_state_t     state_r;
   logic [SET_W-1:0] fill_set_r;
   logic [WAY_W-1:0] fill_way_r;
   logic [WAY_W-1:0] wway_r;
   logic             wway_v_r;
   logic [WAY_W-1:0] victim_s;
   logic [WAY_W-1:0] policy_victim_s;
   logic [15:0]      lfsr_q;
   logic             unused_bits;

   bw_dcache_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk (clk),
      .rst (rst),
      .q   (lfsr_q)
   );

`ifdef BW_DCACHE_PLRU_EN
   logic [WAYS-2:0]           tree_r [SETS];
   logic                      touch_en_s;
   logic [SET_W-1:0]          touch_set_s;
   logic [WAY_W-1:0]          touch_way_s;
   logic [WAYS-2:0]           touch_tree_s;
   logic [WAYS-2:0]           inv_tree_s;
   logic [PLRU_MAX_NODES-1:0] t_touch_s, t_inv_s, t_vic_s;
   logic [PLRU_MAX_NODES-1:0] n_touch_s, n_inv_s;
   logic [PLRU_MAX_LEVELS-1:0] w_touch_s, w_inv_s, w_vic_s;

   // Which set/way gets a touch this cycle: an IDLE hit, or the fill way on completion.
   always_comb begin
      touch_en_s  = 1'b0;
      touch_set_s = acc_set;
      touch_way_s = hit_way;
      case (state_r)
         IDLE: begin
            touch_en_s = acc_v && hit && !miss_v;
         end
         FILL: begin
            if (fill_done) begin
               touch_en_s  = 1'b1;
               touch_set_s = fill_set_r;
               touch_way_s = fill_way_r;
            end else begin
               touch_en_s = 1'b0;
            end
         end
         default: begin
            touch_en_s = 1'b0;
         end
      endcase
   end

   // Widen the per-set trees to the helper width and back.
   always_comb begin
      t_touch_s = '0;
      t_inv_s   = '0;
      t_vic_s   = '0;
      w_touch_s = '0;
      w_inv_s   = '0;
      t_touch_s[WAYS-2:0] = tree_r[touch_set_s];
      t_inv_s[WAYS-2:0]   = tree_r[acc_set];
      t_vic_s[WAYS-2:0]   = tree_r[acc_set];
      w_touch_s[WAY_W-1:0] = touch_way_s;
      w_inv_s[WAY_W-1:0]   = inv_way;
      n_touch_s = plru_touch(t_touch_s, w_touch_s, WAY_W);
      n_inv_s   = plru_point(t_inv_s, w_inv_s, WAY_W);
      w_vic_s   = plru_victim(t_vic_s, WAY_W);
      touch_tree_s    = n_touch_s[WAYS-2:0];
      inv_tree_s      = n_inv_s[WAYS-2:0];
      policy_victim_s = w_vic_s[WAY_W-1:0];
   end

   // Replacement state update; an invalidate wins over a touch of the same set.
   always_ff @(posedge clk) begin
      for (int s = 0; s < SETS; s++) begin
         if (rst) begin
            tree_r[s] <= '0;
         end else if (inv_v && (acc_set == SET_W'(s))) begin
            tree_r[s] <= inv_tree_s;
         end else if (touch_en_s && (touch_set_s == SET_W'(s))) begin
            tree_r[s] <= touch_tree_s;
         end else begin
            tree_r[s] <= tree_r[s];
         end
      end
   end
`else
   assign policy_victim_s = lfsr_q[WAY_W-1:0];
`endif

   assign unused_bits = ^{lfsr_q, inv_way, fill_way_r};

   // Lowest-index invalid way beats the replacement policy.
   always_comb begin
      victim_s = policy_victim_s;
      for (int i = WAYS - 1; i >= 0; i--) begin
         victim_s = way_valid[i] ? victim_s : WAY_W'(i);
      end
   end

   // IDLE/FILL sequencing of the write way.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         fill_set_r <= '0;
         fill_way_r <= '0;
         wway_r     <= '0;
         wway_v_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (miss_v) begin
                  wway_r     <= victim_s;
                  wway_v_r   <= 1'b1;
                  fill_set_r <= acc_set;
                  fill_way_r <= victim_s;
                  state_r    <= FILL;
               end else if (acc_v && hit && acc_store && !inv_v) begin
                  wway_r <= hit_way;
               end else begin
                  wway_r <= wway_r;
               end
            end
            FILL: begin
               // A store to the set being filled must not steal the fill way.
               if (acc_v && hit && acc_store && (acc_set != fill_set_r)) begin
                  wway_r <= hit_way;
               end else begin
                  wway_r <= wway_r;
               end
               if (fill_done) begin
                  wway_v_r <= 1'b0;
                  state_r  <= IDLE;
               end else begin
                  state_r <= FILL;
               end
            end
            default: begin
               wway_v_r <= 1'b0;
               state_r  <= IDLE;
            end
         endcase
      end
   end

   assign wway     = wway_r;
   assign wway_v   = wway_v_r;
   assign miss_rdy = (state_r == IDLE);

endmodule

// File: tb/tb_bw_dcache_way_sel.sv
// Directed scoreboard bench for bw_dcache_way_sel (WAYS=4, SETS=64); honours BW_DCACHE_PLRU_EN.
module tb_bw_dcache_way_sel;

   logic       clk;
   logic       rst;
   logic       acc_v, acc_store, hit, miss_v, fill_done, inv_v;
   logic [5:0] acc_set;
   logic [1:0] hit_way, inv_way;
   logic [3:0] way_valid;
   logic       miss_rdy;
   logic [1:0] wway;
   logic       wway_v;

   typedef struct {
      string      tag;
      logic [1:0] wway;
      logic       wway_v;
      logic       miss_rdy;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [1:0]  ew;
   logic        ev;
   logic [15:0] ref_lfsr;

   bw_dcache_way_sel #(.WAYS(4), .SETS(64), .LFSR_SEED(16'hACE1)) dut (
      .clk       (clk),
      .rst       (rst),
      .acc_v     (acc_v),
      .acc_store (acc_store),
      .acc_set   (acc_set),
      .hit       (hit),
      .hit_way   (hit_way),
      .way_valid (way_valid),
      .miss_v    (miss_v),
      .miss_rdy  (miss_rdy),
      .fill_done (fill_done),
      .inv_v     (inv_v),
      .inv_way   (inv_way),
      .wway      (wway),
      .wway_v    (wway_v)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference LFSR: x^16+x^14+x^13+x^11+1, Galois, seeded in reset.
   always @(posedge clk) begin
      if (rst) ref_lfsr <= 16'hACE1;
      else     ref_lfsr <= (ref_lfsr >> 1) ^ (ref_lfsr[0] ? 16'hB400 : 16'h0000);
   end

   task automatic clear_inputs();
      acc_v = 1'b0; acc_store = 1'b0; hit = 1'b0; miss_v = 1'b0;
      fill_done = 1'b0; inv_v = 1'b0; acc_set = 6'd0; hit_way = 2'd0;
      inv_way = 2'd0; way_valid = 4'hF;
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         assert ({wway, wway_v, miss_rdy} === {e.wway, e.wway_v, e.miss_rdy})
         else begin
            errors++;
            $error("FAIL %s: observed wway=%0d wway_v=%0b miss_rdy=%0b expected wway=%0d wway_v=%0b miss_rdy=%0b",
                   e.tag, wway, wway_v, miss_rdy, e.wway, e.wway_v, e.miss_rdy);
         end
      end
      clear_inputs();
   endtask

   task automatic chk_tick(input string tag);
      sb.push_back('{tag: tag, wway: ew, wway_v: ev, miss_rdy: !ev});
      tick();
   endtask

   task automatic miss(input logic [5:0] s, input logic [3:0] vld);
      miss_v = 1'b1; acc_set = s; way_valid = vld;
   endtask

   task automatic hit_acc(input logic [5:0] s, input logic [1:0] w, input logic st);
      acc_v = 1'b1; hit = 1'b1; acc_set = s; hit_way = w; acc_store = st;
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1; ew = 2'd0; ev = 1'b0;
      tick();
      chk_tick("reset");
      rst = 1'b0;
      chk_tick("idle_after_reset");

      miss(6'd5, 4'b1011); ew = 2'd2; ev = 1'b1;
      chk_tick("miss_prefers_invalid");
      miss(6'd5, 4'b0000);
      chk_tick("miss_ignored_in_fill");
      fill_done = 1'b1; ev = 1'b0;
      chk_tick("fill_done");

      hit_acc(6'd1, 2'd3, 1'b1); ew = 2'd3;
      chk_tick("store_hit_idle");
      hit_acc(6'd1, 2'd1, 1'b0);
      chk_tick("load_hit_keeps_wway");
      fill_done = 1'b1;
      chk_tick("fill_done_in_idle");

      miss(6'd7, 4'b1110); ew = 2'd0; ev = 1'b1;
      chk_tick("miss_set7");
      miss(6'd7, 4'b1011);
      chk_tick("second_miss_ignored");
      hit_acc(6'd7, 2'd1, 1'b1);
      chk_tick("store_same_set_holds");
      hit_acc(6'd9, 2'd2, 1'b1); ew = 2'd2;
      chk_tick("store_other_set_in_fill");
      fill_done = 1'b1; ev = 1'b0;
      chk_tick("fill_done_set7");

`ifdef BW_DCACHE_PLRU_EN
      for (int w = 0; w < 4; w++) begin
         hit_acc(6'd3, 2'(w), 1'b0);
         chk_tick("plru_load_hit");
      end
      miss(6'd3, 4'hF); ew = 2'd0; ev = 1'b1;
      chk_tick("plru_victim_after_0123");
      fill_done = 1'b1; ev = 1'b0;
      chk_tick("plru_fill_done_a");
      hit_acc(6'd3, 2'd0, 1'b0);
      chk_tick("plru_hit0");
      hit_acc(6'd3, 2'd2, 1'b0);
      chk_tick("plru_hit2");
      miss(6'd3, 4'hF); ew = 2'd1; ev = 1'b1;
      chk_tick("plru_victim_after_02");
      fill_done = 1'b1; ev = 1'b0;
      chk_tick("plru_fill_done_b");

      inv_v = 1'b1; acc_set = 6'd2; inv_way = 2'd2;
      chk_tick("inv_set2");
      miss(6'd2, 4'hF); ew = 2'd2; ev = 1'b1;
      chk_tick("inv_victim");
      fill_done = 1'b1; ev = 1'b0;
      chk_tick("inv_fill_done");
      hit_acc(6'd2, 2'd0, 1'b0); inv_v = 1'b1; inv_way = 2'd2;
      chk_tick("inv_with_same_set_hit");
      miss(6'd2, 4'hF); ew = 2'd2; ev = 1'b1;
      chk_tick("inv_overrides_touch");
      fill_done = 1'b1; ev = 1'b0;
      chk_tick("inv_fill_done_b");
`else
      for (int g = 0; g < 4; g++) begin
         repeat (g * 3 + 1) chk_tick("lfsr_gap");
         miss(6'(g + 10), 4'hF); ew = ref_lfsr[1:0]; ev = 1'b1;
         chk_tick("lfsr_victim");
         fill_done = 1'b1; ev = 1'b0;
         chk_tick("lfsr_fill_done");
      end
`endif

      miss(6'd4, 4'b1101); ew = 2'd1; ev = 1'b1;
      chk_tick("miss_before_rst");
      rst = 1'b1; ew = 2'd0; ev = 1'b0;
      chk_tick("rst_mid_fill");
      rst = 1'b0;
      chk_tick("idle_after_rst");
`ifdef BW_DCACHE_PLRU_EN
      miss(6'd3, 4'hF); ew = 2'd0; ev = 1'b1;
`else
      miss(6'd3, 4'hF); ew = ref_lfsr[1:0]; ev = 1'b1;
`endif
      chk_tick("policy_after_rst");
      fill_done = 1'b1; ev = 1'b0;
      chk_tick("fill_done_after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bw_dcache_way_sel.md
Name: bw_dcache_way_sel

Overview:
- Parametrised data-cache way-selection and replacement unit for the BlackWidow dcache.
- Tracks per-set replacement state and selects a victim way on a miss, preferring invalid ways.
- Supplies the write way for store hits and line fills; serialises fills through a small FSM.
- Sits beside the dcache tag/data arrays and is driven by the memory-stage state machine.

Parameters:
- WAYS, 4, number of ways; power of two, 2..8.
- SETS, 64, number of sets; power of two.
- LFSR_SEED, 16'hACE1, non-zero reset value of the internal 16-bit LFSR.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- acc_v  in  1  cache access (hit check) this cycle.
- acc_store  in  1  access is a store (includes MOVST/CALL stores).
- acc_set  in  $clog2(SETS)  set index of the access, miss, or invalidate.
- hit  in  1  tag hit for the access.
- hit_way  in  $clog2(WAYS)  way that hit.
- way_valid  in  WAYS  valid bits of the addressed set.
- miss_v  in  1  request a victim for a fill.
- miss_rdy  out  1  high in IDLE only.
- fill_done  in  1  final beat of the line fill written.
- inv_v  in  1  invalidate a way.
- inv_way  in  $clog2(WAYS)  way being invalidated.
- wway  out  $clog2(WAYS)  write way for the store hit or the fill.
- wway_v  out  1  wway is valid for a fill in progress.

Behaviour:
- Reset: wway=0, wway_v=0, FSM in IDLE, LFSR=LFSR_SEED, all replacement state cleared to 0.
- Replacement state: tree pseudo-LRU, WAYS-1 bits per set.
- Touching way w sets each tree node on w's path to point away from w.
- Victim: the tree is walked from the root following the node bits.
- LFSR: Galois form, x^16+x^14+x^13+x^11+1; advances every cycle when not in reset.
- FSM states: IDLE, FILL.
- IDLE, acc_v&hit, not inv_v: touch hit_way in acc_set.
  - If acc_store, wway <= hit_way on the next edge.
  - Loads leave wway unchanged.
- IDLE, miss_v: victim is the lowest-index way with way_valid=0. If all ways are valid, the policy victim is used.
  - wway <= victim, wway_v <= 1, move to FILL; latency is 1 cycle.
  - miss_v has priority over a same-cycle acc_v; the access is not counted.
- FILL: miss_rdy=0 and miss_v is ignored.
  - Store hits still update wway only if acc_set differs from the fill set. Otherwise wway holds the victim.
- FILL, fill_done: touch wway in the fill set (latched at miss), wway_v <= 0, return to IDLE.
- inv_v, any state: set the tree bits of acc_set so that inv_way becomes the next victim.
  - inv_v overrides a same-cycle touch of the same set.
- fill_done in IDLE: ignored.
- rst during FILL: the fill is abandoned; outputs take their reset values next edge.
- All index arithmetic is unsigned; no wrap concerns beyond the power-of-two sizes.

Optional Feature:
- BW_DCACHE_PLRU_EN.
- Defined: pseudo-LRU victim as described.
- Undefined:
  - No tree state is built.
  - The policy victim is LFSR[$clog2(WAYS)-1:0].
  - Touch and invalidate-pointer updates are removed.
  - Invalid-way preference remains.

Decomposition:
- Package bw_dcache_pkg:
  - dcway_state_t enum (IDLE, FILL).
  - LFSR tap constant.
  - Helper function plru_touch(tree, way).
  - Helper function plru_victim(tree).
- Sub-module bw_dcache_lfsr16: free-running 16-bit LFSR with seed parameter, used here and reusable by the icache.

Test Plan:
- Reset, then miss_v on set 5 with way_valid=4'b1011 -> 1 cycle later wway=2, wway_v=1, miss_rdy=0. fill_done -> wway_v=0, IDLE.
- PLRU enabled, set 3 all valid, load hits on ways 0,1,2,3 in order, then miss -> victim way 0. Hits on 0,2 then miss -> victim way 1.
- Store hit on way 3 in IDLE -> wway=3 next cycle, wway_v stays 0. Load hit on way 1 -> wway remains 3.
- During FILL of set 7, second miss_v -> ignored, miss_rdy=0. Store hit on set 7 way 1 -> wway holds victim.
- inv_v set 2 way 2, then miss on set 2 with all valid -> victim 2. Same-cycle hit on set 2 way 0 does not alter the result.
- PLRU disabled, all valid, miss issued at known cycle count after reset -> wway equals low bits of the reference LFSR model. rst mid-FILL -> wway=0, wway_v=0.
